axi_address_decoder_aw_route: RTL

Write-address-channel decoder for one AXI target port of the node, directly upstream of the write-data decoder. Compares AWADDR against per-master-port address regions and routes AWVALID/AWREADY to the single matching initiator port. Pushes a one-hot destination into the write-data decoder's destination FIFO. On decode miss, sequences the write-data error drain and returns a DECERR B response.

---
 rtl/axi_node_pkg.sv | 20 ++
 rtl/axi_address_decoder_aw_route_if.sv | 46 ++++
 rtl/axi_region_match.sv | 40 ++++
 rtl/axi_address_decoder_aw_route.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared types and constants for the AXI node write-address decode path.
package axi_node_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  // AW decoder sequencing: normal routing, then the decode-miss error path.
  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ERR_DATA,
    ERR_RESP
  } aw_state_e;

  // Counter width able to hold every value 0..max_value inclusive.
  function automatic int cnt_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/axi_address_decoder_aw_route_if.sv
// Bus bundle between the AW decoder and its neighbours: slave AW, per-master AW,
// DW destination FIFO, write-data error control and the error B channel.
interface axi_address_decoder_aw_route_if #(
  parameter int N_INIT_PORT   = 4,
  parameter int AXI_ADDRESS_W = 32,
  parameter int AXI_ID_W      = 6
);

  logic                     awvalid_i;
  logic [AXI_ADDRESS_W-1:0] awaddr_i;
  logic [AXI_ID_W-1:0]      awid_i;
  logic                     awready_o;

  logic [N_INIT_PORT-1:0]   awvalid_o;
  logic [N_INIT_PORT-1:0]   awready_i;

  logic [N_INIT_PORT-1:0]   DEST_o;
  logic                     push_DEST_o;
  logic                     grant_FIFO_DEST_i;

  logic                     wdata_burst_done_i;
  logic                     handle_error_o;
  logic                     wdata_error_completed_i;

  logic                     bvalid_o;
  logic [AXI_ID_W-1:0]      bid_o;
  logic [1:0]               bresp_o;
  logic                     bready_i;

  // Decoder side.
  modport slave (
    input  awvalid_i, awaddr_i, awid_i, awready_i, grant_FIFO_DEST_i,
           wdata_burst_done_i, wdata_error_completed_i, bready_i,
    output awready_o, awvalid_o, DEST_o, push_DEST_o, handle_error_o,
           bvalid_o, bid_o, bresp_o
  );

  // Environment side (upstream master, downstream ports, DW decoder).
  modport master (
    output awvalid_i, awaddr_i, awid_i, awready_i, grant_FIFO_DEST_i,
           wdata_burst_done_i, wdata_error_completed_i, bready_i,
    input  awready_o, awvalid_o, DEST_o, push_DEST_o, handle_error_o,
           bvalid_o, bid_o, bresp_o
  );

endinterface

// File: rtl/axi_region_match.sv
// Combinational address-to-master-port decode: region compare, connectivity mask,
// lowest-index priority to a one-hot result.
module axi_region_match #(
  parameter int N_INIT_PORT   = 4,
  parameter int N_REGION      = 2,
  parameter int AXI_ADDRESS_W = 32
) (
  input  logic [AXI_ADDRESS_W-1:0]                      addr,
  input  logic [N_REGION*N_INIT_PORT*AXI_ADDRESS_W-1:0] start_addr,
  input  logic [N_REGION*N_INIT_PORT*AXI_ADDRESS_W-1:0] end_addr,
  input  logic [N_REGION*N_INIT_PORT-1:0]               enable_region,
  input  logic [N_INIT_PORT-1:0]                        connectivity_map,
  output logic [N_INIT_PORT-1:0]                        hit_onehot,
  output logic                                          hit
);

  logic [N_INIT_PORT-1:0] raw_hit;
  logic [N_INIT_PORT-1:0] masked_hit;

  // Region r of port k lives at flat slot r*N_INIT_PORT + k.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    raw_hit = '0;
    for (int k = 0; k < N_INIT_PORT; k++) begin
      for (int r = 0; r < N_REGION; r++) begin
        if (enable_region[r*N_INIT_PORT + k] &&
            addr >= start_addr[(r*N_INIT_PORT + k)*AXI_ADDRESS_W +: AXI_ADDRESS_W] &&
            addr <= end_addr[(r*N_INIT_PORT + k)*AXI_ADDRESS_W +: AXI_ADDRESS_W]) begin
          raw_hit[k] = 1'b1;
        end
      end
    end
  end

  assign masked_hit = raw_hit & connectivity_map;
  // Two's-complement trick isolates the lowest set bit.
  assign hit_onehot = masked_hit & (~masked_hit + N_INIT_PORT'(1));
  assign hit        = |masked_hit;

endmodule

// File: rtl/axi_address_decoder_aw_route.sv
// AW-channel decoder for one target port: routes AW to the matching master port,
// feeds the DW destination FIFO and runs the DECERR path on a decode miss.
module axi_address_decoder_aw_route
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT     = 4,
  parameter int N_REGION        = 2,
  parameter int AXI_ADDRESS_W   = 32,
  parameter int AXI_ID_W        = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  axi_address_decoder_aw_route_if.slave                 bus,
  input  logic [N_REGION*N_INIT_PORT*AXI_ADDRESS_W-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*AXI_ADDRESS_W-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]               enable_region_i,
  input  logic [N_INIT_PORT-1:0]                        connectivity_map_i
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  aw_state_e              state_q, state_d;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic [AXI_ID_W-1:0]    id_q;
  logic                   capture_id;

  logic [N_INIT_PORT-1:0] hit_onehot;
  logic                   hit;
  logic                   qualified;

  logic                   awready;
  logic [N_INIT_PORT-1:0] awvalid;
  logic [N_INIT_PORT-1:0] dest;
  logic                   push;
  logic                   handle_error;
  logic                   bvalid;
  logic [AXI_ID_W-1:0]    bid;
  logic [1:0]             bresp;

  axi_region_match #(
    .N_INIT_PORT   (N_INIT_PORT),
    .N_REGION      (N_REGION),
    .AXI_ADDRESS_W (AXI_ADDRESS_W)
  ) u_region_match (
    .addr             (bus.awaddr_i),
    .start_addr       (START_ADDR_i),
    .end_addr         (END_ADDR_i),
    .enable_region    (enable_region_i),
    .connectivity_map (connectivity_map_i),
    .hit_onehot       (hit_onehot),
    .hit              (hit)
  );

  // A routed AW may only go out while the DW FIFO and the outstanding budget have room.
  assign qualified = bus.awvalid_i & bus.grant_FIFO_DEST_i &
                     (out_cnt_q < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    state_d      = state_q;
    capture_id   = 1'b0;
    awready      = 1'b0;
    awvalid      = '0;
    dest         = '0;
    push         = 1'b0;
    handle_error = 1'b0;
    bvalid       = 1'b0;
    bid          = '0;
    bresp        = BRESP_OKAY;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          awvalid = qualified ? hit_onehot : '0;
          awready = qualified & |(bus.awready_i & hit_onehot);
          push    = bus.awvalid_i & awready;
          dest    = push ? hit_onehot : '0;
        end else if (bus.awvalid_i) begin
          // Miss: swallow the AW immediately and remember whom to answer.
          awready    = 1'b1;
          capture_id = 1'b1;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        // Error data must not be interleaved behind still-pending routed bursts.
        if (out_cnt_q == '0) begin
          state_d = ERR_DATA;
        end
      end

      ERR_DATA: begin
        handle_error = 1'b1;
        if (bus.wdata_error_completed_i) begin
          state_d = ERR_RESP;
        end
      end

      ERR_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = BRESP_DECERR;
        if (bus.bready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Push and done cancel; a done with nothing outstanding is dropped.
  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case ({push, bus.wdata_burst_done_i})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = (out_cnt_q == '0) ? out_cnt_q : out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_cnt_q <= '0;
      id_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      if (capture_id) begin
        id_q <= bus.awid_i;
      end
    end
  end

  no_done_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(bus.wdata_burst_done_i && !push && out_cnt_q == '0)
  );

  assign bus.awready_o      = awready;
  assign bus.awvalid_o      = awvalid;
  assign bus.DEST_o         = dest;
  assign bus.push_DEST_o    = push;
  assign bus.handle_error_o = handle_error;
  assign bus.bvalid_o       = bvalid;
  assign bus.bid_o          = bid;
  assign bus.bresp_o        = bresp;

endmodule
